// File: rtl/spi_burst_engine.sv
// spi_burst_engine: moves a burst of bytes through an MMIO-attached SPI master.
// Each byte: DATA write, settle, STATUS poll until done, DATA read into RX FIFO.
// Optional feature macro: SPI_BURST_CRC16_EN (CRC16-CCITT over received bytes).

// First-word fall-through byte FIFO; pointers wrap on the power-of-2 depth.
module spi_burst_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wp, rp;
  logic [AW:0]             cnt;
  logic                    we, re;

  // Push while full and pop while empty are simply dropped.
  assign we    = wr & ~full;
  assign re    = rd & ~empty;
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign rdata = mem[rp];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (we) wp <= wp + AW'(1);
      if (re) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(we) - (AW+1)'(re);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (we) mem[wp] <= wdata;
  end
endmodule

module spi_burst_engine #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] SPI_BASE   = 32'h80000050
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  len,
  input  logic        fill_mode,
  input  logic [7:0]  fill_byte,
  input  logic        tx_wr,
  input  logic [7:0]  tx_wdata,
  output logic        tx_full,
  input  logic        rx_rd,
  output logic [7:0]  rx_rdata,
  output logic        rx_empty,
  output logic        busy,
  output logic        done_irq,
  output logic [9:0]  bytes_left,
  output logic        m_valid,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic [15:0] crc_out
);
  localparam int          SETTLE_CYC = 2;
  localparam logic [31:0] DATA_ADDR  = SPI_BASE + 32'd4;
  localparam logic [31:0] STAT_ADDR  = SPI_BASE + 32'd8;

  typedef enum logic [2:0] {
    IDLE, ISSUE_WR, SETTLE, POLL, READ, NEXT
  } state_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mmio_req_t;

  state_t                  state, state_nx;
  mmio_req_t               req;
  logic [10:0]             byte_cnt;
  logic                    fill_q;
  logic [7:0]              fbyte_q;
  logic                    abort_pend;
  logic                    gap;
  logic [SETTLE_CYC-1:0]   settle_pipe;
  logic                    ack, wr_ack, ending;
  logic                    tx_pop, rx_push;
  logic [7:0]              tx_rdata;
  logic                    tx_empty, rx_full;
  logic                    unused_rdata;

  assign unused_rdata = ^m_rdata[31:8];

  spi_burst_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx (
    .clk(clk), .reset(reset), .wr(tx_wr), .wdata(tx_wdata), .rd(tx_pop),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  spi_burst_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx (
    .clk(clk), .reset(reset), .wr(rx_push), .wdata(m_rdata[7:0]), .rd(rx_rd),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  assign ack        = req.valid & m_ready;
  assign wr_ack     = ack & (state == ISSUE_WR);
  assign ending     = (byte_cnt == 11'd1) | abort_pend | abort;
  assign busy       = (state != IDLE);
  assign bytes_left = byte_cnt[9:0];
  assign m_valid    = req.valid;
  assign m_write    = req.write;
  assign m_addr     = req.addr;
  assign m_wdata    = req.wdata;
  assign m_wstrb    = req.wstrb;

  // Next-state, MMIO request and FIFO strobes. gap forces one idle cycle
  // after every ack; the request bus is all-zero whenever not requesting.
  always_comb begin
    state_nx = state;
    req      = '0;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    done_irq = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = ISSUE_WR;
      end
      ISSUE_WR: begin
        if (!gap && !((!fill_q && tx_empty) || rx_full)) begin
          req.valid = 1'b1;
          req.write = 1'b1;
          req.addr  = DATA_ADDR;
          req.wdata = {24'h0, (fill_q ? fbyte_q : tx_rdata)};
          req.wstrb = 4'b0001;
          if (m_ready) begin
            tx_pop   = ~fill_q;
            state_nx = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (settle_pipe[SETTLE_CYC-1]) state_nx = POLL;
      end
      POLL: begin
        if (!gap) begin
          req.valid = 1'b1;
          req.addr  = STAT_ADDR;
          if (m_ready && m_rdata[1:0] == 2'b10) state_nx = READ;
        end
      end
      READ: begin
        if (!gap) begin
          req.valid = 1'b1;
          req.addr  = DATA_ADDR;
          if (m_ready) begin
            rx_push  = 1'b1;
            state_nx = NEXT;
          end
        end
      end
      NEXT: begin
        if (ending) begin
          done_irq = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = ISSUE_WR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register plus ack-gap and settle delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gap         <= 1'b0;
      settle_pipe <= '0;
    end else begin
      state       <= state_nx;
      gap         <= ack;
      settle_pipe <= {settle_pipe[SETTLE_CYC-2:0], wr_ack};
    end
  end

  // Burst parameters, byte counter and pending abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt   <= '0;
      fill_q     <= 1'b0;
      fbyte_q    <= '0;
      abort_pend <= 1'b0;
    end else if (state == IDLE) begin
      abort_pend <= 1'b0;
      if (start) begin
        byte_cnt <= (len == 10'd0) ? 11'd1024 : {1'b0, len};
        fill_q   <= fill_mode;
        fbyte_q  <= fill_byte;
      end
    end else begin
      if (abort) abort_pend <= 1'b1;
      if (state == NEXT) begin
        byte_cnt <= byte_cnt - 11'd1;
        if (ending) abort_pend <= 1'b0;
      end
    end
  end

`ifdef SPI_BURST_CRC16_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // CRC16-CCITT over each byte pushed into the RX FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      crc_q <= 16'h0000;
    else if (state == IDLE && start) crc_q <= 16'h0000;
    else if (rx_push)               crc_q <= crc16_upd(crc_q, m_rdata[7:0]);
  end

  assign crc_out = crc_q;
`else
  assign crc_out = 16'h0000;
`endif
endmodule

// File: tb/tb_spi_burst_engine.sv
// Bench for spi_burst_engine: table of single-burst vectors plus directed
// sequences for stalls, abort, FIFO limits and reset. Slave acks combinationally.
module tb_spi_burst_engine;
  localparam logic [31:0] SB = 32'h80000050;

  logic        clk = 1'b0;
  logic        reset, start, abort, fill_mode, tx_wr, rx_rd, m_ready;
  logic [9:0]  len;
  logic [7:0]  fill_byte, tx_wdata, rx_rdata;
  logic        tx_full, rx_empty, busy, done_irq, m_valid, m_write;
  logic [9:0]  bytes_left;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [15:0] crc_out;

  always #10 clk = ~clk;

  spi_burst_engine dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .len(len),
    .fill_mode(fill_mode), .fill_byte(fill_byte), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
    .tx_full(tx_full), .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
    .busy(busy), .done_irq(done_irq), .bytes_left(bytes_left), .m_valid(m_valid),
    .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .crc_out(crc_out)
  );

  // ---------------- slave model ----------------
  logic [7:0] slave_data;
  int         st_busy_init, st_cnt;
  logic       slave_hold;

  assign m_ready = m_valid & ~(slave_hold & m_write);

  always_comb begin
    m_rdata = 32'h0;
    if (m_addr == SB + 32'd8) m_rdata = {30'h0, (st_cnt != 0) ? 2'b01 : 2'b10};
    else                      m_rdata = {24'h0, slave_data};
  end

  always @(posedge clk) begin
    if (m_valid && m_ready) begin
      if (m_write) st_cnt <= st_busy_init;
      else if (m_addr == SB + 32'd8 && st_cnt != 0) st_cnt <= st_cnt - 1;
    end
  end

  // ---------------- bus monitor ----------------
  logic [7:0] wr_q[$];
  int cyc, last_wr_cyc, last_st_cyc, st_reads, data_reads, done_cnt;
  int gap_err, settle_err, proto_err;
  logic prev_ack, poll_first;

  initial begin
    cyc = 0; st_reads = 0; data_reads = 0; done_cnt = 0;
    gap_err = 0; settle_err = 0; proto_err = 0;
    prev_ack = 0; poll_first = 0; last_wr_cyc = 0; last_st_cyc = 0; st_cnt = 0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (prev_ack && m_valid) gap_err <= gap_err + 1;
    if (!busy && (m_valid || m_write || m_addr != 0 || m_wdata != 0 || m_wstrb != 0))
      proto_err <= proto_err + 1;
    if (done_irq) done_cnt <= done_cnt + 1;
    if (m_valid && m_ready) begin
      if (m_write) begin
        if (m_addr !== SB + 32'd4 || m_wstrb !== 4'b0001 || m_wdata[31:8] !== 24'h0)
          proto_err <= proto_err + 1;
        wr_q.push_back(m_wdata[7:0]);
        last_wr_cyc <= cyc;
        poll_first  <= 1'b1;
      end else if (m_addr == SB + 32'd8) begin
        st_reads <= st_reads + 1;
        if (poll_first) begin
          if (cyc - last_wr_cyc != 3) settle_err <= settle_err + 1;
          poll_first <= 1'b0;
        end else if (cyc - last_st_cyc != 2) gap_err <= gap_err + 1;
        last_st_cyc <= cyc;
      end else if (m_addr == SB + 32'd4) data_reads <= data_reads + 1;
      else proto_err <= proto_err + 1;
    end
    prev_ack <= m_valid && m_ready;
  end

  // ---------------- helpers ----------------
  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [9:0] l, input logic f, input logic [7:0] fb, input logic ab);
    @(posedge clk); #1;
    len = l; fill_mode = f; fill_byte = fb; start = 1'b1; abort = ab;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int i;
    for (i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_wr(input int n, input int budget);
    int i;
    for (i = 0; i < budget && wr_q.size() < n; i++) @(posedge clk);
    if (wr_q.size() < n) chk("wr_timeout", wr_q.size(), n);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(posedge clk); #1;
    tx_wr = 1'b1; tx_wdata = b;
    @(posedge clk); #1;
    tx_wr = 1'b0;
  endtask

  task automatic drain(output int n, output logic [7:0] first);
    n = 0; first = 8'h0;
    while (!rx_empty && n < 64) begin
      if (n == 0) first = rx_rdata;
      n++;
      rx_rd = 1'b1;
      @(posedge clk); #1;
      rx_rd = 1'b0;
    end
  endtask

  typedef struct {
    logic [9:0] len;
    logic       fill;
    logic [7:0] fbyte;
    logic [7:0] sdata;
    int         st_busy;
    int         exp_st;
  } vec_t;

  vec_t vecs[4];
  int   d0, w0, s0, r0, n, bad;
  logic [7:0] first;

  initial begin
    vecs[0] = '{10'd1, 1'b1, 8'hFF, 8'hA5, 0, 1};
    vecs[1] = '{10'd1, 1'b1, 8'h3C, 8'h96, 5, 6};
    vecs[2] = '{10'd4, 1'b1, 8'h00, 8'h11, 1, 8};
    vecs[3] = '{10'd2, 1'b1, 8'h81, 8'h7E, 2, 6};

    reset = 1'b1; start = 0; abort = 0; len = 0; fill_mode = 0; fill_byte = 0;
    tx_wr = 0; tx_wdata = 0; rx_rd = 0; slave_data = 0; st_busy_init = 0; slave_hold = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_irq, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mwrite", m_write, 0);
    chk("rst_bytes_left", bytes_left, 0);
    chk("rst_crc", crc_out, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Table-driven single bursts.
    for (int v = 0; v < 4; v++) begin
      d0 = done_cnt; w0 = wr_q.size(); s0 = st_reads; r0 = data_reads;
      st_busy_init = vecs[v].st_busy; slave_data = vecs[v].sdata;
      pulse_start(vecs[v].len, vecs[v].fill, vecs[v].fbyte, 1'b0);
      wait_done(d0, 2000);
      chk($sformatf("v%0d_done_once", v), done_cnt - d0, 1);
      chk($sformatf("v%0d_writes", v), wr_q.size() - w0, vecs[v].len);
      bad = 0;
      for (int k = w0; k < wr_q.size(); k++) if (wr_q[k] !== vecs[v].fbyte) bad++;
      chk($sformatf("v%0d_wdata", v), bad, 0);
      chk($sformatf("v%0d_status_reads", v), st_reads - s0, vecs[v].exp_st);
      chk($sformatf("v%0d_data_reads", v), data_reads - r0, vecs[v].len);
      chk($sformatf("v%0d_bytes_left", v), bytes_left, 0);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_crc", v), crc_out, 0);
      drain(n, first);
      chk($sformatf("v%0d_rx_count", v), n, vecs[v].len);
      chk($sformatf("v%0d_rx_data", v), first, vecs[v].sdata);
    end
    st_busy_init = 0;

    // TX FIFO data in order.
    w0 = wr_q.size(); d0 = done_cnt; slave_data = 8'h42;
    push_tx(8'h01); push_tx(8'h02); push_tx(8'h03);
    pulse_start(10'd3, 1'b0, 8'h00, 1'b0);
    wait_done(d0, 2000);
    chk("tx_order_count", wr_q.size() - w0, 3);
    chk("tx_order_data", {wr_q[w0], wr_q[w0+1], wr_q[w0+2]}, 24'h010203);
    drain(n, first);
    chk("tx_order_rx", n, 3);

    // Empty TX stalls; start while busy ignored.
    w0 = wr_q.size(); d0 = done_cnt;
    pulse_start(10'd2, 1'b0, 8'h00, 1'b0);
    repeat (20) @(posedge clk); #1;
    chk("txempty_mvalid", m_valid, 0);
    chk("txempty_busy", busy, 1);
    chk("txempty_nowrite", wr_q.size() - w0, 0);
    pulse_start(10'd5, 1'b1, 8'hEE, 1'b0);
    push_tx(8'h5A); push_tx(8'h6B);
    wait_done(d0, 2000);
    chk("busy_start_count", wr_q.size() - w0, 2);
    chk("busy_start_data", {wr_q[w0], wr_q[w0+1]}, 16'h5A6B);
    drain(n, first);

    // Abort in IDLE ignored; start+abort together starts normally.
    w0 = wr_q.size(); d0 = done_cnt;
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    pulse_start(10'd2, 1'b1, 8'h11, 1'b1);
    wait_done(d0, 2000);
    chk("start_abort_writes", wr_q.size() - w0, 2);
    chk("start_abort_left", bytes_left, 0);
    drain(n, first);

    // m_ready withheld: request held steady.
    w0 = wr_q.size(); d0 = done_cnt; slave_hold = 1'b1;
    pulse_start(10'd1, 1'b1, 8'hC3, 1'b0);
    repeat (15) @(posedge clk); #1;
    chk("hold_mvalid", m_valid, 1);
    chk("hold_wdata", m_wdata, 32'hC3);
    chk("hold_nowrite", wr_q.size() - w0, 0);
    slave_hold = 1'b0;
    wait_done(d0, 2000);
    chk("hold_writes", wr_q.size() - w0, 1);
    drain(n, first);

    // Abort during POLL of the third byte.
    w0 = wr_q.size(); d0 = done_cnt; st_busy_init = 3;
    pulse_start(10'd8, 1'b1, 8'h5A, 1'b0);
    wait_wr(w0 + 3, 2000);
    repeat (3) @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done(d0, 2000);
    repeat (20) @(posedge clk); #1;
    chk("abort_done_once", done_cnt - d0, 1);
    chk("abort_writes", wr_q.size() - w0, 3);
    chk("abort_bytes_left", bytes_left, 5);
    drain(n, first);
    chk("abort_rx", n, 3);
    st_busy_init = 0;

    // RX FIFO full stalls the engine after FIFO_DEPTH bytes.
    w0 = wr_q.size(); d0 = done_cnt; slave_data = 8'h44;
    pulse_start(10'd20, 1'b1, 8'h33, 1'b0);
    wait_wr(w0 + 16, 2000);
    repeat (30) @(posedge clk); #1;
    chk("rxfull_writes", wr_q.size() - w0, 16);
    chk("rxfull_mvalid", m_valid, 0);
    chk("rxfull_busy", busy, 1);
    rx_rd = 1'b1;
    repeat (4) @(posedge clk); #1 rx_rd = 1'b0;
    wait_done(d0, 2000);
    chk("rxfull_final_writes", wr_q.size() - w0, 20);
    drain(n, first);
    chk("rxfull_rx", n, 16);

    // TX full, dropped push, then reset mid-burst.
    for (int i = 0; i < 16; i++) push_tx(8'h10 + 8'(i));
    chk("tx_full", tx_full, 1);
    push_tx(8'hEE);
    w0 = wr_q.size(); d0 = done_cnt;
    pulse_start(10'd16, 1'b0, 8'h00, 1'b0);
    wait_done(d0, 4000);
    bad = 0;
    for (int k = 0; k < 16; k++) if (wr_q[w0+k] !== 8'h10 + 8'(k)) bad++;
    chk("txfull_data", bad, 0);
    chk("txfull_not_full", tx_full, 0);
    drain(n, first);
    w0 = wr_q.size();
    pulse_start(10'd1, 1'b0, 8'h00, 1'b0);
    repeat (20) @(posedge clk); #1;
    chk("dropped_push", wr_q.size() - w0, 0);
    chk("stall_busy", busy, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mvalid", m_valid, 0);
    chk("async_rst_left", bytes_left, 0);
    @(posedge clk); #1 reset = 1'b0;

`ifdef SPI_BURST_CRC16_EN
    d0 = done_cnt; slave_data = 8'hFF;
    fork
      begin
        pulse_start(10'd512, 1'b1, 8'hFF, 1'b0);
        wait_done(d0, 20000);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        while (busy) begin
          @(posedge clk); #1;
          rx_rd = ~rx_empty;
        end
        rx_rd = 1'b0;
      end
    join
    chk("crc_512_ff", crc_out, 16'h7FA1);
    drain(n, first);
`endif

    chk("gap_violations", gap_err, 0);
    chk("settle_violations", settle_err, 0);
    chk("protocol_violations", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
